// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared constants for the hardwired control unit of the 8-bit accumulator
//   CPU: opcode values, ALU function-select codes, bus source codes, the FSM
//   state type and the instruction-class record produced by ctrl_decode.
//
//   Optional feature macro: CTRL_HALT_EN
//     defined   -> opcode 8'hFF halts the machine (ST_HALT exists)
//     undefined -> 8'hFF is an ordinary NOP and ST_HALT is not part of the FSM
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcodes held in IR. Anything not listed here executes as NOP.
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_JUMP = 8'h05;
  localparam logic [7:0] OP_JMPZ = 8'h06;
  localparam logic [7:0] OP_JPNZ = 8'h07;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_INAC = 8'h0A;
  localparam logic [7:0] OP_CLAC = 8'h0B;
  localparam logic [7:0] OP_AND  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_XOR  = 8'h0E;
  localparam logic [7:0] OP_NOT  = 8'h0F;
  localparam logic [7:0] OP_HALT = 8'hFF;

  // ALU function select. IDLE tri-states the ALU output onto the bus.
  localparam logic [3:0] ALUS_CLAC = 4'b0000;
  localparam logic [3:0] ALUS_ADD  = 4'b0001;
  localparam logic [3:0] ALUS_SUB  = 4'b0010;
  localparam logic [3:0] ALUS_INAC = 4'b0011;
  localparam logic [3:0] ALUS_AND  = 4'b0100;
  localparam logic [3:0] ALUS_OR   = 4'b0101;
  localparam logic [3:0] ALUS_NOT  = 4'b0110;
  localparam logic [3:0] ALUS_XOR  = 4'b0111;
  localparam logic [3:0] ALUS_PASS = 4'b1000;
  localparam logic [3:0] ALUS_IDLE = 4'b1111;

  // Internal bus source select.
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_DR   = 3'd2;
  localparam logic [2:0] BUS_DRTR = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_R    = 3'd5;

  // Control states.
  //   F1..F3 : opcode fetch
  //   EX     : decode / single-cycle execute
  //   N1     : second PC increment of an untaken conditional jump
  //   A1..A4 : 16-bit address operand fetch (low byte into TR, high in DR)
  //   L1,L2  : LDAC data read and AC load
  //   S1,S2  : STAC data staging and memory write
  typedef enum logic [3:0] {
    ST_F1,
    ST_F2,
    ST_F3,
    ST_EX,
    ST_N1,
    ST_A1,
    ST_A2,
    ST_A3,
    ST_A4,
    ST_L1,
    ST_L2,
    ST_S1,
    ST_S2
`ifdef CTRL_HALT_EN
    ,
    ST_HALT
`endif
  } state_t;

  // Instruction class flags decoded from IR.
  //   alu1    : AC-only ALU op (INAC, CLAC, NOT), nothing driven on the bus
  //   alu2    : ALU op with R on the bus (MOVR, ADD, SUB, AND, OR, XOR)
  //   mvac    : copy AC into R
  //   mem     : LDAC / STAC, needs an address operand
  //   store   : STAC (qualifies mem)
  //   jump    : JUMP / JMPZ / JPNZ, needs an address operand when taken
  //   cond    : conditional jump (qualifies jump)
  //   cond_nz : condition is "Z clear" rather than "Z set"
  //   halt    : halt request (never set unless CTRL_HALT_EN)
  typedef struct packed {
    logic alu1;
    logic alu2;
    logic mvac;
    logic mem;
    logic store;
    logic jump;
    logic cond;
    logic cond_nz;
    logic halt;
  } instr_class_t;

  // A jump is taken when it is unconditional or its Z condition holds.
  function automatic logic jump_is_taken(input instr_class_t cls, input logic z);
    logic cond_ok;
    cond_ok = cls.cond_nz ? ~z : z;
    return cls.jump & (~cls.cond | cond_ok);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
//   Purely combinational opcode decoder. Turns the IR value into instruction
//   class flags and the ALU function code used during EX. Sequencing is left
//   to cpu_ctrl.
//
//   Ports
//     ir      in   8  opcode from IR register
//     cls     out     instruction class flags (instr_class_t)
//     alu_op  out  4  ALU code for alu1/alu2 classes, ALUS_IDLE otherwise
//
//   Optional feature macro: CTRL_HALT_EN (enables decode of 8'hFF as halt)
// ---------------------------------------------------------------------------
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [7:0]   ir,
  output instr_class_t cls,
  output logic [3:0]   alu_op
);

  always_comb begin
    cls    = '0;
    alu_op = ALUS_IDLE;
    unique case (ir)
      OP_LDAC: cls.mem = 1'b1;
      OP_STAC: begin
        cls.mem   = 1'b1;
        cls.store = 1'b1;
      end
      OP_MVAC: cls.mvac = 1'b1;
      OP_MOVR: begin
        cls.alu2 = 1'b1;
        alu_op   = ALUS_PASS;
      end
      OP_JUMP: cls.jump = 1'b1;
      OP_JMPZ: begin
        cls.jump = 1'b1;
        cls.cond = 1'b1;
      end
      OP_JPNZ: begin
        cls.jump    = 1'b1;
        cls.cond    = 1'b1;
        cls.cond_nz = 1'b1;
      end
      OP_ADD: begin
        cls.alu2 = 1'b1;
        alu_op   = ALUS_ADD;
      end
      OP_SUB: begin
        cls.alu2 = 1'b1;
        alu_op   = ALUS_SUB;
      end
      OP_INAC: begin
        cls.alu1 = 1'b1;
        alu_op   = ALUS_INAC;
      end
      OP_CLAC: begin
        cls.alu1 = 1'b1;
        alu_op   = ALUS_CLAC;
      end
      OP_AND: begin
        cls.alu2 = 1'b1;
        alu_op   = ALUS_AND;
      end
      OP_OR: begin
        cls.alu2 = 1'b1;
        alu_op   = ALUS_OR;
      end
      OP_XOR: begin
        cls.alu2 = 1'b1;
        alu_op   = ALUS_XOR;
      end
      OP_NOT: begin
        cls.alu1 = 1'b1;
        alu_op   = ALUS_NOT;
      end
`ifdef CTRL_HALT_EN
      OP_HALT: cls.halt = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl
//   Hardwired Moore control unit of the 8-bit accumulator CPU. Steps through
//   fetch, address-operand fetch and execute, one state per clock, and drives
//   the ALU select, bus source, register load/increment strobes and memory
//   read/write requests. Memory states stall until mem_ready; while stalled
//   only the memory request is asserted, so every output stays constant.
//
//   Cycle counts with mem_ready held high (one per state visited):
//     1-byte ops F1 F2 F3 EX                     -> 4
//     untaken    F1 F2 F3 EX N1                  -> 5
//     taken jump F1 F2 F3 EX A1 A2 A3 A4         -> 8
//     LDAC/STAC  F1 F2 F3 EX A1 A2 A3 A4 L1/S1 L2/S2 -> 10
//
//   Ports
//     clk        in   1  system clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     ir         in   8  opcode from IR register
//     z          in   1  Z flag register, looked at only in EX
//     mem_ready  in   1  memory handshake complete
//     alus       out  4  ALU function select, 4'b1111 = idle
//     bus_sel    out  3  bus source (0 none,1 PC,2 DR,3 {DR,TR},4 AC,5 R)
//     ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld, ir_ld, ac_ld, r_ld, z_ld
//                out  1  datapath register load / increment strobes
//     mem_rd     out  1  memory read request (address = AR)
//     mem_wr     out  1  memory write request (data = DR)
//     halted     out  1  FSM parked in HALT
//
//   Optional feature macro: CTRL_HALT_EN
//     defined   -> opcode 8'hFF in EX parks the FSM in HALT until reset
//     undefined -> 8'hFF runs as NOP and halted is constant 0
// ---------------------------------------------------------------------------
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       z,
  input  logic       mem_ready,
  output logic [3:0] alus,
  output logic [2:0] bus_sel,
  output logic       ar_ld,
  output logic       ar_inc,
  output logic       pc_ld,
  output logic       pc_inc,
  output logic       dr_ld,
  output logic       tr_ld,
  output logic       ir_ld,
  output logic       ac_ld,
  output logic       r_ld,
  output logic       z_ld,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
);

  state_t       state;
  state_t       next_state;
  instr_class_t cls;
  logic [3:0]   alu_op;
  logic         taken;

  ctrl_decode u_decode (
    .ir     (ir),
    .cls    (cls),
    .alu_op (alu_op)
  );

  assign taken = jump_is_taken(cls, z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_F1;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are gated by rst_n so that asserting reset silences every strobe
  // (notably mem_wr) in the same cycle, not just from the next state on.
  always_comb begin
    next_state = state;
    alus       = ALUS_IDLE;
    bus_sel    = BUS_NONE;
    ar_ld      = 1'b0;
    ar_inc     = 1'b0;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    dr_ld      = 1'b0;
    tr_ld      = 1'b0;
    ir_ld      = 1'b0;
    ac_ld      = 1'b0;
    r_ld       = 1'b0;
    z_ld       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;

    if (rst_n) begin
      unique case (state)
        ST_F1: begin
          bus_sel    = BUS_PC;
          ar_ld      = 1'b1;
          next_state = ST_F2;
        end

        ST_F2: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dr_ld      = 1'b1;
            pc_inc     = 1'b1;
            next_state = ST_F3;
          end
        end

        ST_F3: begin
          bus_sel    = BUS_DR;
          ir_ld      = 1'b1;
          next_state = ST_EX;
        end

        // IR was loaded at the end of F3, so ir is valid here and stays
        // stable until the next F3.
        ST_EX: begin
          next_state = ST_F1;
          if (cls.halt) begin
`ifdef CTRL_HALT_EN
            next_state = ST_HALT;
`endif
          end else if (cls.mem || taken) begin
            bus_sel    = BUS_PC;
            ar_ld      = 1'b1;
            next_state = ST_A1;
          end else if (cls.jump) begin
            // Untaken conditional jump skips its two address bytes.
            pc_inc     = 1'b1;
            next_state = ST_N1;
          end else if (cls.alu2) begin
            bus_sel = BUS_R;
            alus    = alu_op;
            ac_ld   = 1'b1;
            z_ld    = 1'b1;
          end else if (cls.alu1) begin
            alus  = alu_op;
            ac_ld = 1'b1;
            z_ld  = 1'b1;
          end else if (cls.mvac) begin
            bus_sel = BUS_AC;
            r_ld    = 1'b1;
          end
        end

        ST_N1: begin
          pc_inc     = 1'b1;
          next_state = ST_F1;
        end

        // Low address byte: AR steps to the high byte as the read completes.
        ST_A1: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dr_ld      = 1'b1;
            pc_inc     = 1'b1;
            ar_inc     = 1'b1;
            next_state = ST_A2;
          end
        end

        ST_A2: begin
          bus_sel    = BUS_DR;
          tr_ld      = 1'b1;
          next_state = ST_A3;
        end

        ST_A3: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dr_ld      = 1'b1;
            pc_inc     = 1'b1;
            next_state = ST_A4;
          end
        end

        // Full 16-bit operand {DR,TR} is on the bus: it becomes either the
        // data address (LDAC/STAC) or the new PC (taken jump).
        ST_A4: begin
          bus_sel = BUS_DRTR;
          if (cls.mem) begin
            ar_ld      = 1'b1;
            next_state = cls.store ? ST_S1 : ST_L1;
          end else begin
            pc_ld      = 1'b1;
            next_state = ST_F1;
          end
        end

        ST_L1: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dr_ld      = 1'b1;
            next_state = ST_L2;
          end
        end

        ST_L2: begin
          bus_sel    = BUS_DR;
          alus       = ALUS_PASS;
          ac_ld      = 1'b1;
          z_ld       = 1'b1;
          next_state = ST_F1;
        end

        ST_S1: begin
          bus_sel    = BUS_AC;
          dr_ld      = 1'b1;
          next_state = ST_S2;
        end

        ST_S2: begin
          mem_wr = 1'b1;
          if (mem_ready) begin
            next_state = ST_F1;
          end
        end

`ifdef CTRL_HALT_EN
        ST_HALT: begin
          halted     = 1'b1;
          next_state = ST_HALT;
        end
`endif

        default: next_state = ST_F1;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl
//   Directed, table-driven bench for cpu_ctrl. Each table row is one clock:
//   inputs to drive plus the hand-computed output word
//   {alus, bus_sel, strobes[9:0], mem_rd, mem_wr, halted}.
//   Strobe order: ar_ld ar_inc pc_ld pc_inc dr_ld tr_ld ir_ld ac_ld r_ld z_ld.
//   Inputs change on the falling edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl;

  localparam logic [9:0] AR_LD  = 10'h200;
  localparam logic [9:0] AR_INC = 10'h100;
  localparam logic [9:0] PC_LD  = 10'h080;
  localparam logic [9:0] PC_INC = 10'h040;
  localparam logic [9:0] DR_LD  = 10'h020;
  localparam logic [9:0] TR_LD  = 10'h010;
  localparam logic [9:0] IR_LD  = 10'h008;
  localparam logic [9:0] AC_LD  = 10'h004;
  localparam logic [9:0] R_LD   = 10'h002;
  localparam logic [9:0] Z_LD   = 10'h001;
  localparam logic [9:0] NO_STB = 10'h000;
  localparam logic [3:0] IDLE   = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir;
  logic       z;
  logic       mem_ready;
  logic [3:0] alus;
  logic [2:0] bus_sel;
  logic       ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld, ir_ld, ac_ld, r_ld, z_ld;
  logic       mem_rd, mem_wr, halted;
  logic [19:0] act;

  typedef struct {
    string       name;
    logic [7:0]  ir;
    logic        z;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  cpu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir        (ir),
    .z         (z),
    .mem_ready (mem_ready),
    .alus      (alus),
    .bus_sel   (bus_sel),
    .ar_ld     (ar_ld),
    .ar_inc    (ar_inc),
    .pc_ld     (pc_ld),
    .pc_inc    (pc_inc),
    .dr_ld     (dr_ld),
    .tr_ld     (tr_ld),
    .ir_ld     (ir_ld),
    .ac_ld     (ac_ld),
    .r_ld      (r_ld),
    .z_ld      (z_ld),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign act = {alus, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld,
                ir_ld, ac_ld, r_ld, z_ld, mem_rd, mem_wr, halted};

  function automatic logic [19:0] pack(input logic [3:0] a, input logic [2:0] b,
                                       input logic [9:0] s, input logic rd,
                                       input logic wr, input logic h);
    return {a, b, s, rd, wr, h};
  endfunction

  function automatic void addRow(input string name, input logic [7:0] op,
                                 input logic zz, input logic rdy,
                                 input logic [3:0] a, input logic [2:0] b,
                                 input logic [9:0] s, input logic rd,
                                 input logic wr);
    vec_t v;
    v.name = name;
    v.ir   = op;
    v.z    = zz;
    v.rdy  = rdy;
    v.exp  = pack(a, b, s, rd, wr, 1'b0);
    vecs.push_back(v);
  endfunction

  // F1, F2 (with optional stall cycles), F3.
  function automatic void addFetch(input string t, input logic [7:0] op,
                                   input logic zz, input int stall);
    addRow({t, " F1"}, op, zz, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    for (int i = 0; i < stall; i++)
      addRow({t, " F2 stall"}, op, zz, 1'b0, IDLE, 3'd0, NO_STB, 1'b1, 1'b0);
    addRow({t, " F2"}, op, zz, 1'b1, IDLE, 3'd0, DR_LD | PC_INC, 1'b1, 1'b0);
    addRow({t, " F3"}, op, zz, 1'b1, IDLE, 3'd2, IR_LD, 1'b0, 1'b0);
  endfunction

  // A1 (stall), A2, A3 (stall), A4 with caller-chosen A4 strobe.
  function automatic void addAddr(input string t, input logic [7:0] op,
                                  input logic zz, input int stall,
                                  input logic [9:0] a4);
    for (int i = 0; i < stall; i++)
      addRow({t, " A1 stall"}, op, zz, 1'b0, IDLE, 3'd0, NO_STB, 1'b1, 1'b0);
    addRow({t, " A1"}, op, zz, 1'b1, IDLE, 3'd0, DR_LD | PC_INC | AR_INC, 1'b1, 1'b0);
    addRow({t, " A2"}, op, zz, 1'b1, IDLE, 3'd2, TR_LD, 1'b0, 1'b0);
    for (int i = 0; i < stall; i++)
      addRow({t, " A3 stall"}, op, zz, 1'b0, IDLE, 3'd0, NO_STB, 1'b1, 1'b0);
    addRow({t, " A3"}, op, zz, 1'b1, IDLE, 3'd0, DR_LD | PC_INC, 1'b1, 1'b0);
    addRow({t, " A4"}, op, zz, 1'b1, IDLE, 3'd3, a4, 1'b0, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [19:0] exp);
    checks++;
    if (act === exp && !(mem_rd && mem_wr)) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got alus=%b bus=%0d stb=%b rd=%b wr=%b h=%b, want alus=%b bus=%0d stb=%b rd=%b wr=%b h=%b",
               name, act[19:16], act[15:13], act[12:3], act[2], act[1], act[0],
               exp[19:16], exp[15:13], exp[12:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ir        = v.ir;
    z         = v.z;
    mem_ready = v.rdy;
    #1;
    checkOutput(v.name, v.exp);
    @(negedge clk);
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    ir        = 8'h00;
    z         = 1'b0;
    mem_ready = 1'b0;
    #2;
    checkOutput("reset idle", pack(IDLE, 3'd0, NO_STB, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single-byte ALU / register ops.
    addFetch("add", 8'h08, 1'b1, 0);
    addRow("add EX", 8'h08, 1'b1, 1'b1, 4'b0001, 3'd5, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("sub", 8'h09, 1'b0, 0);
    addRow("sub EX", 8'h09, 1'b0, 1'b1, 4'b0010, 3'd5, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("and", 8'h0C, 1'b0, 1);
    addRow("and EX", 8'h0C, 1'b0, 1'b0, 4'b0100, 3'd5, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("or", 8'h0D, 1'b0, 0);
    addRow("or EX", 8'h0D, 1'b0, 1'b1, 4'b0101, 3'd5, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("xor", 8'h0E, 1'b1, 0);
    addRow("xor EX", 8'h0E, 1'b1, 1'b1, 4'b0111, 3'd5, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("movr", 8'h04, 1'b0, 0);
    addRow("movr EX", 8'h04, 1'b0, 1'b1, 4'b1000, 3'd5, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("inac", 8'h0A, 1'b0, 0);
    addRow("inac EX", 8'h0A, 1'b0, 1'b1, 4'b0011, 3'd0, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("clac", 8'h0B, 1'b0, 0);
    addRow("clac EX", 8'h0B, 1'b0, 1'b1, 4'b0000, 3'd0, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("not", 8'h0F, 1'b0, 0);
    addRow("not EX", 8'h0F, 1'b0, 1'b1, 4'b0110, 3'd0, AC_LD | Z_LD, 1'b0, 1'b0);
    addFetch("mvac", 8'h03, 1'b0, 0);
    addRow("mvac EX", 8'h03, 1'b0, 1'b1, IDLE, 3'd4, R_LD, 1'b0, 1'b0);
    addFetch("nop", 8'h00, 1'b0, 0);
    addRow("nop EX", 8'h00, 1'b0, 1'b1, IDLE, 3'd0, NO_STB, 1'b0, 1'b0);
    addFetch("op20", 8'h20, 1'b1, 0);
    addRow("op20 EX", 8'h20, 1'b1, 1'b1, IDLE, 3'd0, NO_STB, 1'b0, 1'b0);

    // Untaken conditionals: two PC increments, no operand reads. z flips in
    // N1 to show it is ignored outside EX.
    addFetch("jmpz0", 8'h06, 1'b0, 0);
    addRow("jmpz0 EX", 8'h06, 1'b0, 1'b1, IDLE, 3'd0, PC_INC, 1'b0, 1'b0);
    addRow("jmpz0 N1", 8'h06, 1'b1, 1'b1, IDLE, 3'd0, PC_INC, 1'b0, 1'b0);
    addFetch("jpnz1", 8'h07, 1'b1, 0);
    addRow("jpnz1 EX", 8'h07, 1'b1, 1'b1, IDLE, 3'd0, PC_INC, 1'b0, 1'b0);
    addRow("jpnz1 N1", 8'h07, 1'b0, 1'b1, IDLE, 3'd0, PC_INC, 1'b0, 1'b0);

    // Taken jumps: operand fetch, PC loaded from {DR,TR}.
    addFetch("jmpz1", 8'h06, 1'b1, 0);
    addRow("jmpz1 EX", 8'h06, 1'b1, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    addAddr("jmpz1", 8'h06, 1'b0, 2, PC_LD);
    addFetch("jpnz0", 8'h07, 1'b0, 0);
    addRow("jpnz0 EX", 8'h07, 1'b0, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    addAddr("jpnz0", 8'h07, 1'b1, 0, PC_LD);
    addFetch("jump", 8'h05, 1'b0, 0);
    addRow("jump EX", 8'h05, 1'b0, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    addAddr("jump", 8'h05, 1'b1, 0, PC_LD);

    // STAC with a stalled write.
    addFetch("stac", 8'h02, 1'b0, 0);
    addRow("stac EX", 8'h02, 1'b0, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    addAddr("stac", 8'h02, 1'b0, 0, AR_LD);
    addRow("stac S1", 8'h02, 1'b0, 1'b1, IDLE, 3'd4, DR_LD, 1'b0, 1'b0);
    addRow("stac S2 stall", 8'h02, 1'b0, 1'b0, IDLE, 3'd0, NO_STB, 1'b0, 1'b1);
    addRow("stac S2 stall", 8'h02, 1'b1, 1'b0, IDLE, 3'd0, NO_STB, 1'b0, 1'b1);
    addRow("stac S2", 8'h02, 1'b0, 1'b1, IDLE, 3'd0, NO_STB, 1'b0, 1'b1);

    // LDAC with every memory request stalled 3 clocks.
    addFetch("ldac", 8'h01, 1'b0, 3);
    addRow("ldac EX", 8'h01, 1'b0, 1'b0, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    addAddr("ldac", 8'h01, 1'b0, 3, AR_LD);
    for (int i = 0; i < 3; i++)
      addRow("ldac L1 stall", 8'h01, 1'b0, 1'b0, IDLE, 3'd0, NO_STB, 1'b1, 1'b0);
    addRow("ldac L1", 8'h01, 1'b0, 1'b1, IDLE, 3'd0, DR_LD, 1'b1, 1'b0);
    addRow("ldac L2", 8'h01, 1'b0, 1'b1, 4'b1000, 3'd2, AC_LD | Z_LD, 1'b0, 1'b0);
    runTable();

    // Reset asserted in the middle of a stalled write.
    addFetch("rst", 8'h02, 1'b0, 0);
    addRow("rst EX", 8'h02, 1'b0, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    addAddr("rst", 8'h02, 1'b0, 0, AR_LD);
    addRow("rst S1", 8'h02, 1'b0, 1'b1, IDLE, 3'd4, DR_LD, 1'b0, 1'b0);
    runTable();
    mem_ready = 1'b0;
    #1;
    checkOutput("rst S2 write", pack(IDLE, 3'd0, NO_STB, 1'b0, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid S2", pack(IDLE, 3'd0, NO_STB, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    addFetch("after rst", 8'h00, 1'b0, 0);
    addRow("after rst EX", 8'h00, 1'b0, 1'b1, IDLE, 3'd0, NO_STB, 1'b0, 1'b0);
    addRow("after rst F1", 8'h00, 1'b0, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    runTable();
    // The F1 row above advanced the FSM to F2; finish that fetch as a NOP.
    addRow("fin F2", 8'h00, 1'b0, 1'b1, IDLE, 3'd0, DR_LD | PC_INC, 1'b1, 1'b0);
    addRow("fin F3", 8'h00, 1'b0, 1'b1, IDLE, 3'd2, IR_LD, 1'b0, 1'b0);
    addRow("fin EX", 8'h00, 1'b0, 1'b1, IDLE, 3'd0, NO_STB, 1'b0, 1'b0);
    runTable();

    // Opcode FF: halt when the feature is built in, NOP otherwise.
    addFetch("ff", 8'hFF, 1'b0, 0);
    addRow("ff EX", 8'hFF, 1'b0, 1'b1, IDLE, 3'd0, NO_STB, 1'b0, 1'b0);
    runTable();
`ifdef CTRL_HALT_EN
    for (int i = 0; i < 20; i++) begin
      ir        = 8'hFF;
      z         = i[0];
      mem_ready = 1'b1;
      #1;
      checkOutput("halt hold", pack(IDLE, 3'd0, NO_STB, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("halt reset", pack(IDLE, 3'd0, NO_STB, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
`endif
    addRow("ff next F1", 8'h00, 1'b0, 1'b1, IDLE, 3'd1, AR_LD, 1'b0, 1'b0);
    runTable();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
